// File: rtl/div_pkg.sv
// ---------------------------------------------------------------------------
// div_pkg: shared FSM state type and default width for the divider. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package div_pkg;

  localparam int DIV_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_e;

endpackage

`default_nettype wire

// File: rtl/div_step.sv
// ---------------------------------------------------------------------------
// div_step: one combinational restoring-division iteration, MSB first. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH:0]   rem_i,
  input  logic [WIDTH-1:0] dvd_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH:0]   rem_o,
  output logic [WIDTH-1:0] dvd_o
);

  logic [WIDTH+1:0] w_shift;
  logic [WIDTH:0]   w_diff;
  logic             w_ge;

  assign w_shift = {rem_i, dvd_i[WIDTH-1]};
  assign w_ge    = (w_shift >= {2'b00, dvs_i});
  assign w_diff  = w_shift[WIDTH:0] - {1'b0, dvs_i};

  // Quotient bits enter at the LSB as dividend bits leave at the MSB.
  assign rem_o = w_ge ? w_diff : w_shift[WIDTH:0];
  assign dvd_o = {dvd_i[WIDTH-2:0], w_ge};

endmodule

`default_nettype wire

// File: rtl/div_seq.sv
// ---------------------------------------------------------------------------
// div_seq: sequential unsigned restoring divider; macro DIV_SEQ_DBZ_EN adds
// a divide-by-zero fast path and dbz output. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module div_seq
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             activate,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] div,
  output logic [WIDTH-1:0] mod,
  output logic             busy,
`ifdef DIV_SEQ_DBZ_EN
  output logic             dbz,
`endif
  output logic             endop
);

  localparam int               CNT_W     = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  div_state_e       state_q, state_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [WIDTH-1:0] mod_q, mod_d;
  logic             endop_q, endop_d;
  logic [WIDTH:0]   w_step_rem;
  logic [WIDTH-1:0] w_step_dvd;
`ifdef DIV_SEQ_DBZ_EN
  logic             dbz_q, dbz_d;
`endif

  div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem_i(rem_q),
    .dvd_i(dvd_q),
    .dvs_i(dvs_q),
    .rem_o(w_step_rem),
    .dvd_o(w_step_dvd)
  );

  always_comb begin
    state_d = state_q;
    dvs_d   = dvs_q;
    dvd_d   = dvd_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    mod_d   = mod_q;
    endop_d = 1'b0;
`ifdef DIV_SEQ_DBZ_EN
    dbz_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        // The IDLE cycle carrying endop is the tail of the previous operation.
        if (activate && !endop_q) begin
          dvd_d = b;
          dvs_d = c;
          rem_d = '0;
          cnt_d = '0;
`ifdef DIV_SEQ_DBZ_EN
          state_d = (c == '0) ? DONE : RUN;
`else
          state_d = RUN;
`endif
        end
      end
      RUN: begin
        rem_d = w_step_rem;
        dvd_d = w_step_dvd;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_STEP) begin
          state_d = DONE;
        end
      end
      DONE: begin
        endop_d = 1'b1;
        state_d = IDLE;
`ifdef DIV_SEQ_DBZ_EN
        if (dvs_q == '0) begin
          div_d = '1;
          mod_d = dvd_q;
          dbz_d = 1'b1;
        end else begin
          div_d = dvd_q;
          mod_d = rem_q[WIDTH-1:0];
        end
`else
        div_d = dvd_q;
        mod_d = rem_q[WIDTH-1:0];
`endif
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      dvs_q   <= '0;
      dvd_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      div_q   <= '0;
      mod_q   <= '0;
      endop_q <= 1'b0;
`ifdef DIV_SEQ_DBZ_EN
      dbz_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      dvs_q   <= dvs_d;
      dvd_q   <= dvd_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      mod_q   <= mod_d;
      endop_q <= endop_d;
`ifdef DIV_SEQ_DBZ_EN
      dbz_q   <= dbz_d;
`endif
    end
  end

  assign div   = div_q;
  assign mod   = mod_q;
  assign endop = endop_q;
  assign busy  = (state_q == RUN) || (state_q == DONE);
`ifdef DIV_SEQ_DBZ_EN
  assign dbz   = dbz_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_div_seq.sv
// ---------------------------------------------------------------------------
// tb_div_seq: directed vector table plus hand sequences for div_seq. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_div_seq;

  typedef struct {
    logic [7:0] b;
    logic [7:0] c;
    logic [7:0] q;
    logic [7:0] r;
    int         lat;
  } vec_t;

`ifdef DIV_SEQ_DBZ_EN
  localparam int DBZ_LAT = 2;
`else
  localparam int DBZ_LAT = 10;
`endif

  logic       clk;
  logic       reset;
  logic       activate;
  logic [7:0] b;
  logic [7:0] c;
  logic [7:0] div;
  logic [7:0] mod;
  logic       busy;
  logic       endop;
  logic       dbz_s;

  int errors;
  int checks;

  div_seq #(
    .WIDTH(8)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .activate(activate),
    .b       (b),
    .c       (c),
    .div     (div),
    .mod     (mod),
    .busy    (busy),
`ifdef DIV_SEQ_DBZ_EN
    .dbz     (dbz_s),
`endif
    .endop   (endop)
  );

`ifndef DIV_SEQ_DBZ_EN
  assign dbz_s = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Latency is the index of the edge that first samples endop high,
  // counting the edge that samples activate as edge 0.
  task automatic run_op(input logic [7:0] bi, input logic [7:0] ci,
                        output int lat, output int busy_cnt,
                        output logic [7:0] q, output logic [7:0] r, output logic z);
    lat      = -1;
    busy_cnt = 0;
    q        = '0;
    r        = '0;
    z        = 1'b0;
    @(negedge clk);
    b        = bi;
    c        = ci;
    activate = 1'b1;
    @(negedge clk);
    activate = 1'b0;
    for (int j = 0; j < 40; j++) begin
      if (busy) busy_cnt++;
      if (endop) begin
        lat = j + 1;
        q   = div;
        r   = mod;
        z   = dbz_s;
        break;
      end
      @(negedge clk);
    end
  endtask

  vec_t vecs[10];

  initial begin
    int         lat;
    int         bcnt;
    int         n;
    int         first_k;
    int         second_k;
    logic [7:0] q;
    logic [7:0] r;
    logic       z;

    errors   = 0;
    checks   = 0;
    reset    = 1'b0;
    activate = 1'b0;
    b        = '0;
    c        = '0;

    vecs[0] = '{8'd13,  8'd5,   8'd2,   8'd3,  10};
    vecs[1] = '{8'd255, 8'd1,   8'd255, 8'd0,  10};
    vecs[2] = '{8'd5,   8'd13,  8'd0,   8'd5,  10};
    vecs[3] = '{8'd100, 8'd7,   8'd14,  8'd2,  10};
    vecs[4] = '{8'd9,   8'd0,   8'd255, 8'd9,  DBZ_LAT};
    vecs[5] = '{8'd200, 8'd200, 8'd1,   8'd0,  10};
    vecs[6] = '{8'd0,   8'd3,   8'd0,   8'd0,  10};
    vecs[7] = '{8'd255, 8'd255, 8'd1,   8'd0,  10};
    vecs[8] = '{8'd254, 8'd16,  8'd15,  8'd14, 10};
    vecs[9] = '{8'd128, 8'd3,   8'd42,  8'd2,  10};

    repeat (3) @(negedge clk);
    check("reset_div", div, 0);
    check("reset_mod", mod, 0);
    check("reset_busy", busy, 0);
    check("reset_endop", endop, 0);
    check("reset_dbz", dbz_s, 0);
    reset = 1'b1;

    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].b, vecs[i].c, lat, bcnt, q, r, z);
      check($sformatf("v%0d_lat", i), lat, vecs[i].lat);
      check($sformatf("v%0d_div", i), q, vecs[i].q);
      check($sformatf("v%0d_mod", i), r, vecs[i].r);
      check($sformatf("v%0d_busy_cycles", i), bcnt, vecs[i].lat - 1);
`ifdef DIV_SEQ_DBZ_EN
      check($sformatf("v%0d_dbz", i), z, (vecs[i].c == 8'd0) ? 1 : 0);
`endif
      @(negedge clk);
      check($sformatf("v%0d_endop_width", i), endop, 0);
    end

    // Operands and activate change mid-RUN: original result, single endop.
    @(negedge clk);
    b = 8'd13; c = 8'd5; activate = 1'b1;
    @(negedge clk);
    activate = 1'b0;
    repeat (2) @(negedge clk);
    b = 8'd77; c = 8'd2; activate = 1'b1;
    repeat (2) @(negedge clk);
    activate = 1'b0; b = 8'd0; c = 8'd0;
    n = 0; q = '0; r = '0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (endop) begin
        if (n == 0) begin
          q = div;
          r = mod;
        end
        n++;
      end
    end
    check("midrun_endop_count", n, 1);
    check("midrun_div", q, 2);
    check("midrun_mod", r, 3);
    check("hold_div", div, 2);
    check("hold_mod", mod, 3);
    check("hold_busy", busy, 0);

    // Reset in RUN cycle 4 with a concurrent activate.
    @(negedge clk);
    b = 8'd200; c = 8'd3; activate = 1'b1;
    @(negedge clk);
    activate = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0; activate = 1'b1;
    @(negedge clk);
    check("abort_div", div, 0);
    check("abort_mod", mod, 0);
    check("abort_busy", busy, 0);
    check("abort_endop", endop, 0);
    reset = 1'b1; activate = 1'b0;
    n = 0;
    bcnt = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (endop) n++;
      if (busy) bcnt++;
    end
    check("abort_no_endop", n, 0);
    check("abort_no_busy", bcnt, 0);
    run_op(8'd100, 8'd7, lat, bcnt, q, r, z);
    check("after_abort_lat", lat, 10);
    check("after_abort_div", q, 14);
    check("after_abort_mod", r, 2);

    // activate held high: starts accepted every 11 cycles.
    @(negedge clk);
    @(negedge clk);
    b = 8'd13; c = 8'd5; activate = 1'b1;
    n = 0; first_k = -1; second_k = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (endop) begin
        if (n == 0) first_k = k;
        if (n == 1) second_k = k;
        n++;
        check($sformatf("b2b_div_%0d", n), div, 2);
        check($sformatf("b2b_mod_%0d", n), mod, 3);
      end
    end
    activate = 1'b0;
    check("b2b_first_lat", first_k + 1, 10);
    check("b2b_spacing", second_k - first_k, 11);
    check("b2b_endop_count", n, 3);
    repeat (15) @(negedge clk);
    check("b2b_drained", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire

// File: doc/div_seq.md
DIV_SEQ -- requirements
Module: div_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand and result width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-004 The block SHALL have port activate, input, 1 bit: start request; sampled only in IDLE.
REQ-005 The block SHALL have port b, input, WIDTH bits: unsigned dividend.
REQ-006 The block SHALL have port c, input, WIDTH bits: unsigned divisor.
REQ-007 The block SHALL have port div, output, WIDTH bits: quotient.
REQ-008 The block SHALL have port mod, output, WIDTH bits: remainder.
REQ-009 The block SHALL have port busy, output, 1 bit: high in RUN and DONE.
REQ-010 The block SHALL have port endop, output, 1 bit: one-cycle pulse marking valid div/mod.

Function
REQ-011 The block SHALL implement FSM states IDLE, RUN and DONE.
REQ-012 In IDLE with activate=1, the block SHALL register b and c, clear the partial remainder and iteration counter, and enter RUN on the next edge.
REQ-013 RUN SHALL last exactly WIDTH cycles, each performing one restoring step, MSB first:
- shift {rem, dividend} left by 1;
- if rem >= divisor: rem -= divisor and quotient bit = 1;
- else quotient bit = 0.
REQ-014 The internal remainder SHALL be WIDTH+1 bits wide so the compare cannot overflow.
REQ-015 After the last RUN cycle, the block SHALL enter DONE, update div/mod, and assert endop for exactly one cycle; DONE SHALL return to IDLE on the next edge.
REQ-016 Latency SHALL be WIDTH+2 edges from the edge that samples activate to the edge at which endop is high; for WIDTH=8 this is 10 edges.
REQ-017 The block SHALL ignore activate while busy=1; operands captured at start SHALL be unaffected by b/c changes during RUN.
REQ-018 The block SHALL hold div/mod stable from DONE until the next DONE.
REQ-019 activate=1 in the same cycle as the DONE-to-IDLE transition SHALL be ignored; a new start SHALL be accepted one cycle after endop.
REQ-020 When b < c, the result SHALL be div=0 and mod=b; when c=1, div=b and mod=0.

Reset
REQ-021 With reset=0 at a rising edge, the block SHALL enter IDLE and set div=0, mod=0, busy=0, endop=0, counter=0, regardless of state.
REQ-022 A reset during RUN SHALL abort the operation with no endop pulse.
REQ-023 activate=1 concurrent with reset=0 SHALL be ignored.

Configuration
REQ-024 With macro DIV_SEQ_DBZ_EN defined:
- the block SHALL add output dbz (1 bit, reset 0);
- if the captured c equals 0, IDLE SHALL go directly to DONE, skipping RUN, with div = all ones, mod = b, and dbz = 1 during the endop cycle;
- dbz SHALL be 0 for all other results.
REQ-025 Without DIV_SEQ_DBZ_EN:
- port dbz SHALL be absent;
- c=0 SHALL run the normal WIDTH-cycle algorithm, which yields div = all ones and mod = b, with normal latency.

Structure
REQ-026 Shared package div_pkg SHALL hold the FSM state typedef (IDLE/RUN/DONE) and the default width constant DIV_WIDTH=8.
REQ-027 One combinational sub-module div_step SHALL perform a single shift/compare/subtract iteration; div_seq SHALL instantiate it once and iterate it.

Verification
REQ-028 The bench SHALL cover b=13, c=5: endop at edge 10 after start, div=2, mod=3, busy high for 9 cycles.
REQ-029 The bench SHALL cover b=255, c=1 and b=5, c=13: results div=255, mod=0 and div=0, mod=5 respectively.
REQ-030 The bench SHALL cover activate pulsed plus b/c changed mid-RUN: a single endop, with the result from the original operands.
REQ-031 The bench SHALL cover reset=0 at RUN cycle 4: no endop, all outputs 0; the next start (b=100, c=7) yields div=14, mod=2.
REQ-032 The bench SHALL cover b=9, c=0:
- with DIV_SEQ_DBZ_EN: endop at edge 2, div=255, mod=9, dbz=1;
- without it: endop at edge 10, div=255, mod=9.
REQ-033 The bench SHALL cover back-to-back starts with activate held high: a new start is accepted each WIDTH+3 cycles, with consecutive endops spaced 11 cycles apart.
